stack_arbiter: RTL and testbench

- Two-client round-robin arbiter and sequencer in front of a single shared LIFO stack.
- Each client issues push/pop requests through a req/ack handshake. The block serialises them onto the stack's push/pop/write_data interface and returns pop data.
- Guards the stack: push-when-full and pop-when-empty are never forwarded. They complete with an error flag instead.
- Overflow and underflow events are counted in saturating counters.

---
 rtl/stack_arbiter.sv | 123 ++++++++++++
 tb/tb_stack_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-client round-robin arbiter serialising push/pop requests onto a shared LIFO.
// Illegal operations (push when full, pop when empty) are absorbed and counted.
module stack_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  op0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  op1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy,
    output logic                  st_push,
    output logic                  st_pop,
    output logic [DATA_WIDTH-1:0] st_wdata,
    input  logic [DATA_WIDTH-1:0] st_rdata,
    input  logic                  st_full,
    input  logic                  st_empty,
    output logic [CNT_WIDTH-1:0]  ovf_cnt,
    output logic [CNT_WIDTH-1:0]  udf_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t                state_q;
    logic                  grant_q;
    logic                  op_q;
    logic                  last_grant_q;
    logic                  err_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  err_out_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CNT_WIDTH-1:0]  ovf_q;
    logic [CNT_WIDTH-1:0]  udf_q;
    logic                  grant_d;

    // On a tie the client that did not win the previous tie is served.
    always_comb begin
        grant_d = 1'b1;
        if (req0) begin
            grant_d = req1 ? ~last_grant_q : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            op_q         <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_out_q    <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ovf_q        <= '0;
            udf_q        <= '0;
        end else begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= grant_d;
                        op_q    <= grant_d ? op1 : op0;
                        wdata_q <= grant_d ? wdata1 : wdata0;
                        if (req0 && req1) begin
                            last_grant_q <= grant_d;
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q && st_full) begin
                        err_q <= 1'b1;
                        if (ovf_q != '1) ovf_q <= ovf_q + 1'b1;
                    end else if (!op_q && st_empty) begin
                        err_q <= 1'b1;
                        if (udf_q != '1) udf_q <= udf_q + 1'b1;
                    end
                    state_q <= CAPT;
                end
                CAPT: begin
                    rdata_q   <= (!op_q && !err_q) ? st_rdata : '0;
                    ack0_q    <= ~grant_q;
                    ack1_q    <= grant_q;
                    err_out_q <= err_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from state so an async reset removes them at once.
    assign st_push  = (state_q == EXEC) && op_q && !st_full;
    assign st_pop   = (state_q == EXEC) && !op_q && !st_empty;
    assign st_wdata = st_push ? wdata_q : '0;

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign err     = err_out_q;
    assign rdata   = rdata_q;
    assign busy    = (state_q != IDLE);
    assign ovf_cnt = ovf_q;
    assign udf_cnt = udf_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: 4-deep LIFO model, directed client traffic,
// expected acks queued at issue and checked by an independent monitor.
module tb_stack_arbiter;

    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err, busy, st_push, st_pop;
    logic [DW-1:0] rdata, st_wdata, st_rdata;
    logic          st_full, st_empty;
    logic [CW-1:0] ovf_cnt, udf_cnt;

    stack_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .wdata0(wdata0),
        .req1(req1), .op1(op1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .st_push(st_push), .st_pop(st_pop), .st_wdata(st_wdata),
        .st_rdata(st_rdata), .st_full(st_full), .st_empty(st_empty),
        .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
    );

    always #5 clk = ~clk;

    // Stack model: registered read data, valid the cycle after st_pop.
    logic [DW-1:0] mem [DEPTH];
    int            cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 0;
            st_rdata <= '0;
        end else if (st_push && cnt < DEPTH) begin
            mem[cnt] <= st_wdata;
            cnt      <= cnt + 1;
        end else if (st_pop && cnt > 0) begin
            st_rdata <= mem[cnt-1];
            cnt      <= cnt - 1;
        end
    end
    assign st_full  = (cnt == DEPTH);
    assign st_empty = (cnt == 0);

    typedef struct {
        logic          c;
        logic [DW-1:0] d;
        logic          e;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (st_push) begin
                push_cnt++;
                check("strobe_overlap", st_pop, 0);
                check("push_when_full", st_full, 0);
            end
            if (st_pop) begin
                pop_cnt++;
                check("pop_when_empty", st_empty, 0);
            end
            if (st_push || st_pop) check("strobe_busy", busy, 1);
            if (ack0 || ack1) begin
                check("dual_ack", ack0 & ack1, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", {ack0, ack1}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("ack_client", ack1, e.c);
                    check("rdata", rdata, e.d);
                    check("err", err, e.e);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_st_push"}, st_push, 0);
        check({tag, "_st_pop"}, st_pop, 0);
        check({tag, "_st_wdata"}, st_wdata, 0);
        check({tag, "_ovf"}, ovf_cnt, 0);
        check({tag, "_udf"}, udf_cnt, 0);
    endtask

    // Single-client operation from IDLE; req-to-ack latency must be 3.
    task automatic do_op(input logic c, input logic op, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_d, input logic exp_e);
        int  k = 0;
        bit  seen = 0;
        sb_q.push_back('{c, exp_d, exp_e});
        @(negedge clk);
        if (c) begin op1 = op; wdata1 = d; req1 = 1'b1; end
        else   begin op0 = op; wdata0 = d; req0 = 1'b1; end
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (ack0 || ack1) seen = 1;
        end
        check("op_latency", seen ? k : -1, 3);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Both clients push n times each with requests held high.
    task automatic run_tie(input int n, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int a0 = 0, a1 = 0, k = 0, prev = -1;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{1'b0, 8'h00, 1'b0});
            sb_q.push_back('{1'b1, 8'h00, 1'b0});
        end
        @(negedge clk);
        op0 = 1'b1; op1 = 1'b1; wdata0 = d0; wdata1 = d1;
        req0 = 1'b1; req1 = 1'b1;
        while ((a0 < n || a1 < n) && k < 40 * n) begin
            @(negedge clk);
            k++;
            if (ack0 || ack1) begin
                if (prev < 0) check("tie_first_latency", k, 3);
                else          check("ack_spacing", k - prev, 4);
                prev = k;
                if (ack0) begin a0++; if (a0 == n) req0 = 1'b0; end
                if (ack1) begin a1++; if (a1 == n) req1 = 1'b0; end
            end
        end
        check("tie_acks", a0 + a1, 2 * n);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int pc;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Push then pop on client 0.
        do_op(1'b0, 1'b1, 8'hA5, 8'h00, 1'b0);
        do_op(1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);

        // Alternating pushes fill the 4-deep stack: 11,22,11,22.
        run_tie(2, 8'h11, 8'h22);
        check("full_after_fill", st_full, 1);

        // Push on full is rejected and counted.
        pc = push_cnt;
        do_op(1'b1, 1'b1, 8'h77, 8'h00, 1'b1);
        check("no_push_on_full", push_cnt, pc);
        check("ovf_cnt", ovf_cnt, 1);

        // Drain: top is unchanged by the rejected push.
        do_op(1'b0, 1'b0, 8'h00, 8'h22, 1'b0);
        do_op(1'b1, 1'b0, 8'h00, 8'h11, 1'b0);
        do_op(1'b0, 1'b0, 8'h00, 8'h22, 1'b0);
        do_op(1'b1, 1'b0, 8'h00, 8'h11, 1'b0);

        // Pop on empty is rejected and counted.
        pc = pop_cnt;
        do_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        check("no_pop_on_empty", pop_cnt, pc);
        check("udf_cnt_one", udf_cnt, 1);

        // Saturation: 259 rejected pops in total.
        for (int i = 0; i < 254; i++) do_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        check("udf_cnt_255", udf_cnt, 255);
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        check("udf_cnt_sat", udf_cnt, 255);
        check("ovf_cnt_keep", ovf_cnt, 1);

        // Reset in the EXEC cycle of a legal push.
        @(negedge clk);
        op0 = 1'b1; wdata0 = 8'h5A; req0 = 1'b1;
        @(negedge clk);
        check("exec_push", st_push, 1);
        check("exec_wdata", st_wdata, 8'h5A);
        #2 rst = 1'b0;
        req0 = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (3) begin
            @(negedge clk);
            check("no_ack_in_reset", ack0 | ack1, 0);
        end
        rst = 1'b1;
        check("sb_empty_before_tie", sb_q.size(), 0);
        run_tie(1, 8'h33, 8'h44);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
